fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port imem_req, output, 1 bit: fetch request to instruction memory.
REQ-005 The block SHALL have port imem_addr, output, 32 bits: fetch address, equal to the internal PC.
REQ-006 The block SHALL have port imem_valid, input, 1 bit: memory read data valid.
REQ-007 The block SHALL have port imem_rdata, input, 32 bits: fetched instruction word.
REQ-008 The block SHALL have port instr, output, 32 bits: held instruction; decode takes imm[31:7] = instr[31:7].
REQ-009 The block SHALL have port pc, output, 32 bits: address of the held instruction.
REQ-010 The block SHALL have port instr_valid, output, 1 bit: instr and pc are valid.
REQ-011 The block SHALL have port instr_ready, input, 1 bit: downstream consumes the instruction.
REQ-012 The block SHALL have port PCsrc, input, 1 bit: branch/jump taken, sampled with instr_ready.
REQ-013 The block SHALL have port ImmExt, input, 32 bits: sign-extended offset from the extender, sampled with instr_ready.
REQ-014 The block SHALL have port misalign_err, output, 1 bit: sticky misaligned-target flag.
REQ-015 The block SHALL have port instr_count, output, 32 bits: count of consumed instructions.

Function
REQ-016 The FSM SHALL have three states: REQ, WAIT and HOLD.
REQ-017 In REQ, imem_req SHALL be 1 and imem_addr SHALL equal PC; the next state SHALL be WAIT unconditionally, since memory accepts every request.
REQ-018 In WAIT, on imem_valid=1 the block SHALL load instr<=imem_rdata and pc<=PC, then go to HOLD; otherwise it SHALL stay in WAIT with no limit.
REQ-019 imem_valid SHALL be ignored in the REQ and HOLD states.
REQ-020 instr_valid SHALL be 1 exactly when the state is HOLD; instr and pc SHALL stay stable throughout HOLD.
REQ-021 In HOLD with instr_ready=1 (handshake), the block SHALL set PC<=pc+ImmExt if PCsrc=1, else PC<=pc+4, and go to REQ.
REQ-022 In HOLD with instr_ready=0, the block SHALL stay in HOLD, and PCsrc and ImmExt SHALL be ignored.
REQ-023 All PC arithmetic SHALL be 32-bit modulo 2^32; 32'hFFFF_FFFC+4 SHALL give 32'h0000_0000 with no error flagged.
REQ-024 If the computed next PC has bits[1:0]!=0, the block SHALL clear those bits in PC and set misalign_err=1, which stays set until reset.
REQ-025 instr_count SHALL increment by 1 on each handshake and wrap from 32'hFFFF_FFFF to 0.
REQ-026 Minimum throughput SHALL be one instruction per 3 cycles: REQ at t, imem_valid at t+1, handshake at t+2, next REQ at t+3.
REQ-027 imem_req SHALL be 0 in WAIT and HOLD, leaving at most one fetch outstanding.

Reset
REQ-028 When rst=1 at a clock edge, the block SHALL set state=REQ, PC=RESET_PC, instr=0, pc=0, misalign_err=0 and instr_count=0.
REQ-029 While rst=1, imem_req and instr_valid SHALL be forced to 0.
REQ-030 rst SHALL override every simultaneous event (imem_valid, handshake).
REQ-031 A mid-operation reset SHALL abandon any outstanding fetch; a late imem_valid arriving in the REQ state SHALL be dropped.
REQ-032 The first imem_req SHALL appear in the first cycle with rst=0, with imem_addr=RESET_PC.

Verification
REQ-033 The bench SHALL cover: rst 1 cycle, memory returns 32'h00500093 at 1-cycle latency, instr_ready=1, PCsrc=0 -> imem_addr sequence 0,4,8 at 3-cycle spacing; instr_valid high with pc=0; instr_count=1 after the first handshake.
REQ-034 The bench SHALL cover: pc=32'h10 held, handshake with PCsrc=1 and ImmExt=32'hFFFF_FFF0 -> next imem_addr=32'h0000_0000.
REQ-035 The bench SHALL cover: instr_ready=0 for 5 cycles in HOLD while PCsrc and ImmExt toggle -> instr and pc constant, no imem_req, and PC unchanged until the handshake.
REQ-036 The bench SHALL cover: PCsrc=1 with ImmExt=32'h6 from pc=32'h20 -> imem_addr=32'h24 and misalign_err=1, still 1 after 10 further instructions; rst -> 0.
REQ-037 The bench SHALL cover: memory latency of 4 cycles with rst asserted in the second WAIT cycle -> next cycle has state REQ and imem_addr=RESET_PC; the stale imem_valid is ignored and instr_valid stays 0.
REQ-038 The bench SHALL cover: instr_count preloaded near wrap by 2^32-1 forced handshakes (or by a test-only force) -> the next handshake yields 0; PC=32'hFFFF_FFFC with PCsrc=0 -> next PC=0 with misalign_err=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: a three-state REQ -> WAIT -> HOLD loop that keeps at
// most one instruction-memory read outstanding. It holds each fetched word until
// downstream consumes it, then computes the next fetch PC.
//
// Handshakes:
//   imem side : imem_req is a one-cycle request pulse with imem_addr. Memory
//               always accepts it, so there is no ready signal. imem_valid
//               qualifies imem_rdata and is only looked at in WAIT.
//   decode    : instr_valid/instr_ready follow strict valid/ready rules.
//               instr_valid stays high with instr and pc stable until a cycle
//               with instr_valid && instr_ready. That cycle is the transfer, and
//               PCsrc/ImmExt are sampled in it.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        PCsrc,
    input  logic [31:0] ImmExt,
    output logic        misalign_err,
    output logic [31:0] instr_count,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] count_q;
    logic [31:0] target;

    // Branch or sequential successor of the held instruction, modulo 2^32.
    assign target = pc + (PCsrc ? ImmExt : 32'd4);

    // Request and valid follow the state, but are masked while reset is high.
    assign imem_req    = (state == S_REQ)  && !rst;
    assign instr_valid = (state == S_HOLD) && !rst;
    assign imem_addr   = fetch_pc;
    assign instr_count = count_q;
    assign dbg_state   = state;

    // Fetch FSM with the PC, held instruction, sticky error and consumed count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_REQ;
            fetch_pc     <= RESET_PC;
            instr        <= 32'd0;
            pc           <= 32'd0;
            misalign_err <= 1'b0;
            count_q      <= 32'd0;
        end else begin
            case (state)
                S_REQ: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (imem_valid) begin
                        instr <= imem_rdata;
                        pc    <= fetch_pc;
                        state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (instr_ready) begin
                        // A misaligned target is forced onto a word boundary and flagged.
                        fetch_pc <= {target[31:2], 2'b00};
                        if (target[1:0] != 2'b00) begin
                            misalign_err <= 1'b1;
                        end
                        count_q <= count_q + 32'd1;
                        state   <= S_REQ;
                    end
                end
                default: begin
                    state <= S_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit. It runs directed scenarios and randomized fetches, and
// checks them against a transaction-level model of the fetch sequence.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] ST_REQ   = 32'd0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        PCsrc = 1'b0;
    logic [31:0] ImmExt = 32'd0;
    logic        misalign_err;
    logic [31:0] instr_count;
    logic [1:0]  dbg_state;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .instr(instr), .pc(pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .PCsrc(PCsrc), .ImmExt(ImmExt),
        .misalign_err(misalign_err), .instr_count(instr_count),
        .dbg_state(dbg_state)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Watchdog so the run always ends.
    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    int checks   = 0;
    int failures = 0;

    // Scoreboard of expected fetch addresses, plus the architectural model state.
    logic [31:0] exp_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_hold_pc;
    logic [31:0] m_instr;
    logic [31:0] m_count;
    logic        m_err;

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc      = RESET_PC;
        m_hold_pc = 32'd0;
        m_instr   = 32'd0;
        m_count   = 32'd0;
        m_err     = 1'b0;
        exp_q.delete();
    endtask

    // Hold reset for some cycles, check the reset state, then release it.
    task automatic do_reset(input int cycles);
        instr_ready = 1'b0;
        imem_valid  = 1'b0;
        PCsrc       = 1'b0;
        rst         = 1'b1;
        repeat (cycles) step();
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_pc", pc, 32'd0);
        check("rst_count", instr_count, 32'd0);
        check("rst_misalign", 32'(misalign_err), 32'd0);
        check("rst_state", 32'(dbg_state), ST_REQ);
        rst = 1'b0;
        #1;
        model_reset();
        exp_q.push_back(RESET_PC);
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", imem_addr, RESET_PC);
    endtask

    // Wait (bounded) for a request, match its address, then move into WAIT.
    task automatic wait_req(output int at);
        int n;
        logic [31:0] exp;
        n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("req_seen", 32'(imem_req), 32'd1);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        check("fetch_addr", imem_addr, exp);
        check("req_no_valid", 32'(instr_valid), 32'd0);
        at = cyc;
        step();
    endtask

    // Memory model: return data lat cycles after the request, starting in WAIT.
    task automatic respond(input int lat, input logic [31:0] data);
        repeat (lat - 1) begin
            check("wait_no_req", 32'(imem_req), 32'd0);
            check("wait_no_valid", 32'(instr_valid), 32'd0);
            imem_rdata = $urandom;
            step();
        end
        imem_rdata = data;
        imem_valid = 1'b1;
        step();
        imem_valid = 1'b0;
        imem_rdata = $urandom;
        m_hold_pc  = m_pc;
        m_instr    = data;
    endtask

    // Stall for delay cycles with noisy inputs, then consume the instruction.
    task automatic hold(input int delay, input logic sel, input logic [31:0] imm);
        logic [31:0] nxt;
        check("hold_valid", 32'(instr_valid), 32'd1);
        check("hold_instr", instr, m_instr);
        check("hold_pc", pc, m_hold_pc);
        repeat (delay) begin
            instr_ready = 1'b0;
            PCsrc       = 1'($urandom_range(0, 1));
            ImmExt      = $urandom;
            imem_valid  = 1'($urandom_range(0, 1));
            imem_rdata  = $urandom;
            step();
            check("stall_valid", 32'(instr_valid), 32'd1);
            check("stall_instr", instr, m_instr);
            check("stall_pc", pc, m_hold_pc);
            check("stall_no_req", 32'(imem_req), 32'd0);
            check("stall_pc_kept", imem_addr, m_pc);
        end
        instr_ready = 1'b1;
        PCsrc       = sel;
        ImmExt      = imm;
        imem_valid  = 1'b0;
        step();
        instr_ready = 1'b0;
        PCsrc       = 1'b0;
        ImmExt      = 32'd0;
        m_count = m_count + 32'd1;
        nxt     = m_hold_pc + (sel ? imm : 32'd4);
        if (nxt % 4 != 0) m_err = 1'b1;
        m_pc = nxt - (nxt % 4);
        exp_q.push_back(m_pc);
        check("hs_count", instr_count, m_count);
        check("hs_misalign", 32'(misalign_err), 32'(m_err));
        check("hs_valid_drop", 32'(instr_valid), 32'd0);
    endtask

    task automatic fetch(input int lat, input int delay, input logic sel,
                         input logic [31:0] imm, input logic [31:0] data, output int at);
        wait_req(at);
        respond(lat, data);
        hold(delay, sel, imm);
    endtask

    task automatic random_fetches(input int n);
        int t;
        repeat (n) begin
            fetch(int'($urandom_range(1, 4)), int'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), $urandom, $urandom, t);
        end
    endtask

    initial begin
        int t0, t1, t2, t;

        // Reset and back-to-back sequential fetches at full throughput.
        do_reset(1);
        fetch(1, 0, 1'b0, 32'd0, 32'h0050_0093, t0);
        check("count_first", instr_count, 32'd1);
        fetch(1, 0, 1'b0, 32'd0, 32'h0050_0093, t1);
        fetch(1, 0, 1'b0, 32'd0, 32'h0050_0093, t2);
        check("spacing_01", 32'(t1 - t0), 32'd3);
        check("spacing_12", 32'(t2 - t1), 32'd3);

        // Backward branch from 0x10 by -16 wraps the fetch back to 0.
        fetch(1, 0, 1'b0, 32'd0, $urandom, t);
        fetch(1, 0, 1'b1, 32'hFFFF_FFF0, $urandom, t);
        check("branch_back_addr", imem_addr, 32'h0000_0000);

        // Long stall in HOLD while PCsrc/ImmExt toggle, then branch to 0x20.
        fetch(2, 5, 1'b1, 32'h0000_0020, $urandom, t);
        check("branch_fwd_addr", imem_addr, 32'h0000_0020);

        // Misaligned target: fetch goes to 0x24, the error sticks until reset.
        fetch(1, 0, 1'b1, 32'h0000_0006, $urandom, t);
        check("misalign_addr", imem_addr, 32'h0000_0024);
        check("misalign_set", 32'(misalign_err), 32'd1);
        random_fetches(10);
        check("misalign_sticky", 32'(misalign_err), 32'd1);
        do_reset(1);

        // Reset lands in the second WAIT cycle of a 4-cycle fetch.
        wait_req(t);
        step();
        rst = 1'b1;
        step();
        check("abort_state", 32'(dbg_state), ST_REQ);
        check("abort_addr", imem_addr, RESET_PC);
        check("abort_req_masked", 32'(imem_req), 32'd0);
        check("abort_no_valid", 32'(instr_valid), 32'd0);
        step();
        rst        = 1'b0;
        imem_valid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        #1;
        model_reset();
        check("stale_req", 32'(imem_req), 32'd1);
        check("stale_addr", imem_addr, RESET_PC);
        check("stale_no_valid", 32'(instr_valid), 32'd0);
        step();
        imem_valid = 1'b0;
        check("stale_dropped", 32'(instr_valid), 32'd0);
        respond(1, 32'h0000_0013);
        hold(0, 1'b1, 32'hFFFF_FFFC);
        check("top_addr", imem_addr, 32'hFFFF_FFFC);

        // Count wrap and PC wrap on the same handshake.
        wait_req(t);
        respond(2, $urandom);
        force dut.count_q = 32'hFFFF_FFFF;
        #1;
        release dut.count_q;
        m_count = 32'hFFFF_FFFF;
        hold(0, 1'b0, 32'd0);
        check("count_wrap", instr_count, 32'd0);
        check("pc_wrap_addr", imem_addr, 32'h0000_0000);
        check("pc_wrap_no_err", 32'(misalign_err), 32'd0);

        // Randomized run against the model.
        random_fetches(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
